// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL lock sequencer.
//   pll_state_e : FSM state encoding, also exported on the debug state port
//   *_DEF       : default cycle/retry parameters for a 27 MHz reference
//   max3        : helper used to size the shared cycle counter
package pll_seq_pkg;

    typedef enum logic [2:0] {
        StPllRst    = 3'd0,
        StWaitLock  = 3'd1,
        StStabilize = 3'd2,
        StRun       = 3'd3,
        StFault     = 3'd4
    } pll_state_e;

    localparam int unsigned PLL_RST_CYCLES_DEF      = 16;
    localparam int unsigned LOCK_TIMEOUT_CYCLES_DEF = 27000; // 1 ms at 27 MHz
    localparam int unsigned LOCK_STABLE_CYCLES_DEF  = 1024;
    localparam int unsigned MAX_RETRIES_DEF         = 3;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/bit_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous status bit.
//   clkin : destination clock
//   rst   : synchronous active-high reset, clears both flops
//   d     : asynchronous input
//   q     : synchronized output
module bit_sync_2ff (
    input  logic clkin,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clkin) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: pulses PLL reset, waits for lock with timeout and
// bounded retries, requires a stable lock before releasing the clkout domain,
// and re-sequences on lock loss.
//   clkin     : reference clock (only clock)
//   rst       : synchronous active-high reset
//   pll_lock  : PLL lock, asynchronous to clkin
//   restart   : single-cycle sequence restart request
//   pll_reset : PLL RESET pin drive, active-high
//   dom_rst   : active-high reset for clkout-domain consumers
//   ready     : PLL locked and stable
//   fault     : retries exhausted
//   retry_cnt : lock timeouts in the current attempt series
//   loss_cnt  : lock losses seen while running, saturating at 255
//   state     : current FSM state, for debug
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned PLL_RST_CYCLES      = PLL_RST_CYCLES_DEF,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = LOCK_TIMEOUT_CYCLES_DEF,
    parameter int unsigned LOCK_STABLE_CYCLES  = LOCK_STABLE_CYCLES_DEF,
    parameter int unsigned MAX_RETRIES         = MAX_RETRIES_DEF
) (
    input  logic       clkin,
    input  logic       rst,
    input  logic       pll_lock,
    input  logic       restart,
    output logic       pll_reset,
    output logic       dom_rst,
    output logic       ready,
    output logic       fault,
    output logic [3:0] retry_cnt,
    output logic [7:0] loss_cnt,
    output logic [2:0] state
);

    localparam int unsigned CNT_MAX =
        max3(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);
    localparam int unsigned CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    pll_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       retry_d;
    logic [7:0]       loss_d;
    logic             pll_reset_d, dom_rst_d, ready_d, fault_d;
    logic             lock_s;

    bit_sync_2ff u_lock_sync (
        .clkin (clkin),
        .rst   (rst),
        .d     (pll_lock),
        .q     (lock_s)
    );

    always_comb begin
        state_d = state_q;
        retry_d = retry_cnt;
        loss_d  = loss_cnt;
        // Saturate so long RUN/FAULT residency can never wrap the counter.
        cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

        if (restart) begin
            state_d = StPllRst;
            retry_d = 4'd0;
        end else begin
            unique case (state_q)
                StPllRst: begin
                    if (cnt_q == CNT_W'(PLL_RST_CYCLES - 1)) state_d = StWaitLock;
                end
                StWaitLock: begin
                    // Lock beats a coincident timeout.
                    if (lock_s) begin
                        state_d = StStabilize;
                    end else if (cnt_q == CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
                        if (retry_cnt == 4'(MAX_RETRIES)) begin
                            state_d = StFault;
                        end else begin
                            retry_d = retry_cnt + 4'd1;
                            state_d = StPllRst;
                        end
                    end
                end
                StStabilize: begin
                    if (!lock_s) begin
                        state_d = StWaitLock;
                    end else if (cnt_q == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
                        state_d = StRun;
                        retry_d = 4'd0;
                    end
                end
                StRun: begin
                    if (!lock_s) begin
                        loss_d  = (loss_cnt == 8'hFF) ? loss_cnt : loss_cnt + 8'd1;
                        state_d = StPllRst;
                    end
                end
                StFault: state_d = StFault;
                default: state_d = StPllRst;
            endcase
        end

        if (restart || (state_d != state_q)) cnt_d = '0;

        // Decode from the next state so the registered outputs line up with state_q.
        pll_reset_d = (state_d == StPllRst) || (state_d == StFault);
        dom_rst_d   = (state_d != StRun);
        ready_d     = (state_d == StRun);
        fault_d     = (state_d == StFault);
    end

    always_ff @(posedge clkin) begin
        if (rst) begin
            state_q   <= StPllRst;
            cnt_q     <= '0;
            retry_cnt <= 4'd0;
            loss_cnt  <= 8'd0;
            pll_reset <= 1'b1;
            dom_rst   <= 1'b1;
            ready     <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_cnt <= retry_d;
            loss_cnt  <= loss_d;
            pll_reset <= pll_reset_d;
            dom_rst   <= dom_rst_d;
            ready     <= ready_d;
            fault     <= fault_d;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with small cycle parameters
// (reset pulse 4, timeout 20, stable 8, max retries 2).
module tb_pll_lock_sequencer;

    logic       clkin    = 1'b0;
    logic       rst      = 1'b1;
    logic       pll_lock = 1'b0;
    logic       restart  = 1'b0;
    logic       pll_reset, dom_rst, ready, fault;
    logic [3:0] retry_cnt;
    logic [7:0] loss_cnt;
    logic [2:0] state;

    int passed = 0;
    int total  = 0;
    int n;

    pll_lock_sequencer #(
        .PLL_RST_CYCLES      (4),
        .LOCK_TIMEOUT_CYCLES (20),
        .LOCK_STABLE_CYCLES  (8),
        .MAX_RETRIES         (2)
    ) dut (
        .clkin     (clkin),
        .rst       (rst),
        .pll_lock  (pll_lock),
        .restart   (restart),
        .pll_reset (pll_reset),
        .dom_rst   (dom_rst),
        .ready     (ready),
        .fault     (fault),
        .retry_cnt (retry_cnt),
        .loss_cnt  (loss_cnt),
        .state     (state)
    );

    always #5 clkin = ~clkin;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish expected finish before 1ms");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Outputs are sampled on the falling edge; inputs change there too.
    task automatic step(input int cycles);
        repeat (cycles) @(negedge clkin);
    endtask

    // Number of consecutive samples (current one included) for which pll_reset
    // keeps its present level; returns on the first sample at the other level.
    task automatic level_len(output int len);
        logic v;
        v   = pll_reset;
        len = 1;
        for (int i = 0; i < 200; i++) begin
            step(1);
            if (pll_reset !== v) break;
            len++;
        end
    endtask

    task automatic wait_ready(input string tag, input int budget);
        for (int i = 0; i < budget && ready !== 1'b1; i++) step(1);
        chk(tag, ready, 1);
    endtask

    task automatic lose_and_relock();
        pll_lock = 1'b0;
        step(3);
        pll_lock = 1'b1;
        wait_ready("relock_ready", 40);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"}, state, 0);
        chk({tag, "_pll_reset"}, pll_reset, 1);
        chk({tag, "_dom_rst"}, dom_rst, 1);
        chk({tag, "_ready"}, ready, 0);
        chk({tag, "_fault"}, fault, 0);
        chk({tag, "_retry"}, retry_cnt, 0);
        chk({tag, "_loss"}, loss_cnt, 0);
    endtask

    initial begin
        // Reset values
        step(3);
        chk_reset_vals("reset");

        // Clean lock: sample after the last reset edge is the first PLL_RST cycle
        rst = 1'b0;
        level_len(n);
        chk("clean_rst_pulse", n, 4);
        step(5);
        pll_lock = 1'b1;
        step(10);
        chk("clean_ready_edge10", ready, 0);
        chk("clean_domrst_edge10", dom_rst, 1);
        step(1);
        chk("clean_ready_edge11", ready, 1);
        chk("clean_domrst_edge11", dom_rst, 0);
        chk("clean_retry", retry_cnt, 0);
        chk("clean_state", state, 3);

        // Glitch during STABILIZE
        restart = 1'b1;
        step(1);
        restart = 1'b0;
        chk("glitch_restart_state", state, 0);
        chk("glitch_restart_ready", ready, 0);
        for (int i = 0; i < 40 && state !== 3'd2; i++) step(1);
        chk("glitch_reach_stab", state, 2);
        step(4);
        pll_lock = 1'b0;
        step(3);
        chk("glitch_back_waitlock", state, 1);
        chk("glitch_ready_low", ready, 0);
        pll_lock = 1'b1;
        step(10);
        chk("glitch_ready_edge10", ready, 0);
        step(1);
        chk("glitch_ready_edge11", ready, 1);
        chk("glitch_loss", loss_cnt, 0);

        // Lock loss in RUN
        pll_lock = 1'b0;
        step(2);
        chk("loss_domrst_2edges", dom_rst, 0);
        step(1);
        chk("loss_domrst_3edges", dom_rst, 1);
        chk("loss_ready_3edges", ready, 0);
        chk("loss_cnt_1", loss_cnt, 1);
        chk("loss_pll_reset", pll_reset, 1);
        level_len(n);
        chk("loss_rst_pulse", n, 4);
        pll_lock = 1'b1;
        step(10);
        chk("loss_relock_edge10", ready, 0);
        step(1);
        chk("loss_relock_edge11", ready, 1);
        chk("loss_relock_state", state, 3);

        // Saturation: 300 more losses on top of the one above
        for (int i = 0; i < 300; i++) lose_and_relock();
        chk("loss_saturated", loss_cnt, 255);

        // No lock: restart with lock low, expect three pulses then FAULT
        pll_lock = 1'b0;
        restart  = 1'b1;
        step(1);
        restart  = 1'b0;
        chk("nolock_loss_kept", loss_cnt, 255);
        chk("nolock_state", state, 0);
        level_len(n);
        chk("nolock_hi1", n, 4);
        level_len(n);
        chk("nolock_lo1", n, 20);
        chk("nolock_retry1", retry_cnt, 1);
        level_len(n);
        chk("nolock_hi2", n, 4);
        level_len(n);
        chk("nolock_lo2", n, 20);
        chk("nolock_retry2", retry_cnt, 2);
        level_len(n);
        chk("nolock_hi3", n, 4);
        level_len(n);
        chk("nolock_lo3", n, 20);
        chk("fault_flag", fault, 1);
        chk("fault_pll_reset", pll_reset, 1);
        chk("fault_retry", retry_cnt, 2);
        chk("fault_state", state, 4);
        step(30);
        chk("fault_hold_flag", fault, 1);
        chk("fault_hold_pll_reset", pll_reset, 1);
        chk("fault_hold_retry", retry_cnt, 2);

        // Restart out of FAULT
        restart = 1'b1;
        step(1);
        restart = 1'b0;
        chk("restart_state", state, 0);
        chk("restart_fault", fault, 0);
        chk("restart_retry", retry_cnt, 0);
        chk("restart_loss", loss_cnt, 255);

        // rst and restart together in RUN with loss_cnt = 5
        rst = 1'b1;
        step(2);
        rst      = 1'b0;
        pll_lock = 1'b1;
        wait_ready("prio_reach_run", 60);
        for (int i = 0; i < 5; i++) lose_and_relock();
        chk("prio_loss5", loss_cnt, 5);
        chk("prio_state_run", state, 3);
        rst     = 1'b1;
        restart = 1'b1;
        step(1);
        chk_reset_vals("prio");
        rst     = 1'b0;
        restart = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
